instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the RISC-V core; sits directly upstream of instruction memory (instr_mem).
//  Holds the PC, drives the combinational instruction-memory address, captures the returned word,
//  buffers {pc,instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
//  Accepts PC redirects (branch/jump/trap) from execute, flushing everything already fetched.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  DEPTH     2              fetch-buffer entries; power of two, >= 2
// PORTS
//  clk             in   1   core clock, all state on rising edge
//  rst_n           in   1   synchronous reset, active low
//  imem_addr       out  32  byte address to instruction memory (= pc)
//  imem_rdata      in   32  instruction word, combinational from imem_addr, same cycle
//  redirect_valid  in   1   load redirect_pc, flush buffer
//  redirect_pc     in   32  new fetch address
//  id_valid        out  1   head entry valid for decode
//  id_ready        in   1   decode accepts head entry
//  id_instr        out  32  head instruction; 32'h0000_0013 (NOP) when empty
//  id_pc           out  32  head PC; 0 when empty
//  fetch_misalign  out  1   only with FETCH_MISALIGN_EN, see CONFIGURATION
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc<=RESET_PC, count<=0, rd/wr ptr<=0; id_valid=0, id_instr=NOP, id_pc=0.
//  imem_addr = pc continuously (combinational), including during reset.
//  pop  = id_valid & id_ready.
//  push = ~redirect_valid & (count<DEPTH | pop). On push: entry<={pc,imem_rdata}, pc<=pc+4 (mod 2^32).
//  No push: pc holds. Full and not popping -> fetch stalls, pc and buffer unchanged.
//  Simultaneous push+pop while full: allowed, count unchanged, order preserved.
//  redirect_valid: pc<=redirect_pc, count<=0, ptrs<=0, no push that cycle; overrides pop (a pop
//   handshake in that cycle still counts as consumed by decode, but buffer is cleared regardless).
//  Redirect and reset mid-stream: no stale instruction ever reaches id_* after the edge.
//  Latency: word at pc appears on id_* one cycle after the push edge; after reset release or
//   redirect, first id_valid=1 exactly 1 cycle later. Steady state with id_ready=1: one instr/cycle.
//  id_* driven from buffer head only (registered), never combinationally from imem_rdata.
//  id_valid = (count!=0). count width $clog2(DEPTH)+1.
// CONFIGURATION
//  FETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0]!=0 sets sticky fetch_misalign<=1,
//   loads pc<=redirect_pc, flushes, and inhibits all pushes until next aligned redirect or reset,
//   which clear it. Reset value 0.
//  Not defined: port absent; redirect_pc[1:0] ignored, pc<={redirect_pc[31:2],2'b00}.
// STRUCTURE
//  fetch_pkg: typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}, localparam NOP_INSTR
//   = 32'h0000_0013, localparam DEFAULT_RESET_PC.
//  Sub-module fetch_fifo (DEPTH-entry circular FIFO of fetch_entry_t, push/pop/flush, count,
//   simultaneous push+pop when full); instr_fetch holds PC logic and handshake.
// TESTING
//  1 reset, id_ready=1, imem returns addr^32'hA5A5_0000 -> id_pc 0,4,8,... one per cycle, first
//    id_valid 1 cycle after rst_n rises, instr matches.
//  2 id_ready=0 for 5 cycles -> count saturates at 2, pc stalls at 8, id_pc stays 0; release ->
//    0,4,8 delivered in order, no gap or duplicate.
//  3 full buffer, redirect_pc=0x100 -> next cycle id_valid=0, following cycle id_pc=0x100;
//    entries 0,4 never seen.
//  4 redirect and pop same cycle, id_ready=1 -> head consumed once, then 0x100 stream, no stale pc.
//  5 rst_n=0 mid-stream with full buffer -> id_valid=0, imem_addr=RESET_PC next cycle.
//  6 FETCH_MISALIGN_EN: redirect 0x102 -> fetch_misalign=1, id_valid stays 0; redirect 0x200 ->
//    flag clears, id_pc=0x200. Without macro: redirect 0x102 -> id_pc=0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch stage.
//   fetch_entry_t    - one fetch-buffer entry {pc, instr}
//   NOP_INSTR        - id_instr value presented while the buffer is empty (addi x0,x0,0)
//   DEFAULT_RESET_PC - default PC loaded on reset
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch_entry_t between fetch and decode.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears pointers and count)
//   flush_i         drop every entry; overrides push and pop in the same cycle
//   push_i, wdata_i write an entry (accepted when not full, or when full and popping)
//   pop_i           remove the head entry (ignored when empty)
//   head_o          current head entry (undefined while empty; caller masks it)
//   count_o         number of stored entries, 0..DEPTH
//   full_o          count_o == DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i & ~flush_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RISC-V fetch stage. Holds the PC, addresses instruction memory
// combinationally, buffers {pc,instr} pairs in fetch_fifo and presents the head
// to decode over valid/ready. Redirects load a new PC and flush the buffer.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   imem_addr         byte address to instruction memory (always = pc)
//   imem_rdata        instruction word for imem_addr, same cycle
//   redirect_valid/pc new fetch address from execute; flushes the buffer
//   id_valid/ready    handshake to decode
//   id_instr, id_pc   head entry; NOP and 0 while empty
//   fetch_misalign    sticky misaligned-redirect flag (FETCH_MISALIGN_EN only)
// Build option: define FETCH_MISALIGN_EN to keep misaligned redirect targets
// as-is, raise fetch_misalign and stop fetching until an aligned redirect or
// reset. Without it, redirect targets are forced to word alignment.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   redirect_target;
  logic          inhibit;
  logic          push, pop;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_wdata;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q, misalign_d;

  assign redirect_target = redirect_pc;
  assign inhibit         = misalign_q;
  assign fetch_misalign  = misalign_q;

  // Every redirect re-evaluates the flag: misaligned sets it, aligned clears it.
  assign misalign_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign inhibit              = 1'b0;
`endif

  assign imem_addr = pc_q;

  assign pop  = id_valid & id_ready;
  assign push = ~redirect_valid & ~inhibit & (~fifo_full | pop);

  assign fifo_wdata = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_target;
    else if (push)      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // The flush drops the head even when decode handshakes it in the same cycle;
  // that entry is still considered consumed by decode.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  // Outputs come from registered buffer state only, never from imem_rdata.
  assign id_valid = (fifo_count != '0);
  assign id_instr = id_valid ? fifo_head.instr : NOP_INSTR;
  assign id_pc    = id_valid ? fifo_head.pc    : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
  logic        id_valid;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  // Instruction memory: word derived from the address so every fetch is unique.
  assign imem_rdata = imem_addr ^ KEY;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered PCs plus the fetch PC.
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_q[$];
  logic        m_mis = 1'b0;
  bit          m_ok  = 1'b0;
  logic [31:0] seen[$];   // PCs decode accepted, in order

  task automatic model_step();
    bit pop;
    if (!rst_n) begin
      m_q.delete();
      m_pc  = RST_PC;
      m_mis = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      pop = (m_q.size() != 0) && id_ready;
      if (redirect_valid) begin
        m_q.delete();
`ifdef FETCH_MISALIGN_EN
        m_pc  = redirect_pc;
        m_mis = (redirect_pc % 4) != 0;
`else
        m_pc  = redirect_pc - (redirect_pc % 4);
`endif
      end else begin
        if (pop) void'(m_q.pop_front());
        if (!m_mis && m_q.size() < DEPTH) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle, mid-period.
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("cmp_imem_addr", imem_addr, m_pc);
      chk("cmp_id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
      chk("cmp_id_pc", id_pc, (m_q.size() != 0) ? m_q[0] : 32'h0);
      chk("cmp_id_instr", id_instr, (m_q.size() != 0) ? (m_q[0] ^ KEY) : NOP);
`ifdef FETCH_MISALIGN_EN
      chk("cmp_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
`endif
      if (id_valid && id_ready) seen.push_back(id_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [47:0] rdy_pat = 48'hB36D_F00F_A55A;

  initial begin
    // 1: reset then streaming
    rst_n = 1'b0; id_ready = 1'b1;
    tick(); tick();
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_imem_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t1_first_valid", {31'b0, id_valid}, 32'd1);
    chk("t1_pc0", id_pc, 32'h0);
    chk("t1_instr0", id_instr, 32'hA5A5_0000);
    tick(); chk("t1_pc4", id_pc, 32'h4);
    tick(); chk("t1_pc8", id_pc, 32'h8);
    chk("t1_instr8", id_instr, 32'hA5A5_0008);

    // 2: backpressure saturates the buffer
    rst_n = 1'b0; id_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t2_stall_pc", id_pc, 32'h0);
    chk("t2_stall_addr", imem_addr, 32'h8);
    seen.delete();
    id_ready = 1'b1;
    tick(); chk("t2_pc4", id_pc, 32'h4);
    tick(); chk("t2_pc8", id_pc, 32'h8);
    tick(); chk("t2_pcC", id_pc, 32'hC);
    chk("t2_seen_n", seen.size(), 32'd3);
    if (seen.size() == 3) begin
      chk("t2_seen0", seen[0], 32'h0);
      chk("t2_seen1", seen[1], 32'h4);
      chk("t2_seen2", seen[2], 32'h8);
    end

    // 3: redirect with full buffer
    rst_n = 1'b0; id_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    seen.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; id_ready = 1'b1;
    chk("t3_flushed", {31'b0, id_valid}, 32'd0);
    chk("t3_addr", imem_addr, 32'h100);
    tick();
    chk("t3_valid", {31'b0, id_valid}, 32'd1);
    chk("t3_pc100", id_pc, 32'h100);
    tick(); chk("t3_pc104", id_pc, 32'h104);
    chk("t3_seen_n", seen.size(), 32'd1);
    if (seen.size() == 1) chk("t3_seen0", seen[0], 32'h100);

    // 4: redirect and pop in the same cycle
    seen.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flushed", {31'b0, id_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h200);
    tick(); chk("t4_pc200", id_pc, 32'h200);
    tick(); chk("t4_pc204", id_pc, 32'h204);
    chk("t4_seen_n", seen.size(), 32'd2);
    if (seen.size() == 2) begin
      chk("t4_seen0", seen[0], 32'h104);
      chk("t4_seen1", seen[1], 32'h200);
    end

    // 5: reset mid-stream with full buffer
    id_ready = 1'b0;
    tick(); tick();
    chk("t5_full_pc", id_pc, 32'h204);
    chk("t5_full_addr", imem_addr, 32'h20C);
    rst_n = 1'b0;
    tick();
    chk("t5_valid", {31'b0, id_valid}, 32'd0);
    chk("t5_addr", imem_addr, RST_PC);
    chk("t5_instr", id_instr, 32'h0000_0013);
    rst_n = 1'b1; id_ready = 1'b1;
    tick(); chk("t5_restart", id_pc, 32'h0);

    // 6: misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
    chk("t6_flag_set", {31'b0, fetch_misalign}, 32'd1);
    chk("t6_addr", imem_addr, 32'h102);
    repeat (3) begin
      tick();
      chk("t6_inhibit", {31'b0, id_valid}, 32'd0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t6_flag_clr", {31'b0, fetch_misalign}, 32'd0);
    tick(); chk("t6_pc200", id_pc, 32'h200);
`else
    chk("t6_addr", imem_addr, 32'h100);
    tick(); chk("t6_pc100", id_pc, 32'h100);
`endif

    // Mixed ready pattern with redirects, checked by the model only
    for (int i = 0; i < 48; i++) begin
      id_ready       = rdy_pat[i];
      redirect_valid = (i == 12) || (i == 25) || (i == 33);
      redirect_pc    = (i == 12) ? 32'h3000 : (i == 25) ? 32'h4006 : 32'h5000;
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
